register_file_8x32: RTL and testbench
=====================================

Name: register_file_8x32

Overview:
- Small general-purpose register file: 8 entries × 32 bits, one synchronous write port, one combinational read port.
- Used as datapath storage in the digital-logic lab designs.
- Writes commit on the rising clock edge; reads are asynchronous, decoded from the read address.

Parameters:
- DATA_WIDTH, 32, width of each register and of the write/read data buses.
- ADDR_WIDTH, 3, address width; the number of registers is 2**ADDR_WIDTH (8 at default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- we  input  1  write enable; a write occurs on a rising edge where we=1 and reset=0.
- wAddr  input  ADDR_WIDTH  write address.
- wData  input  DATA_WIDTH  write data.
- rAddr  input  ADDR_WIDTH  read address.
- rData  output  DATA_WIDTH  contents of register rAddr (combinational).

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Storage: 2**ADDR_WIDTH registers, reg[0]..reg[7], each DATA_WIDTH bits.
  - No hard-wired zero register; reg[0] is writable like the others.
- Reset:
  - On a rising edge with reset=1, every register clears to 0.
  - Reset has priority over we.
  - Asserting reset mid-sequence discards all prior writes at that edge.
  - Before the first reset edge, contents are unspecified.
- Write:
  - On a rising edge with reset=0 and we=1, reg[wAddr] <= wData.
  - Latency: 1 edge. The written value is visible on rData immediately after that edge when rAddr=wAddr.
  - we=0: no register changes, regardless of wAddr/wData.
  - Exactly one register is written per enabled edge; all others hold.
- Read:
  - rData = reg[rAddr], purely combinational, with no clock or enable.
  - Follows rAddr changes within the same cycle.
- Read/write same address in one cycle:
  - rData shows the old value until the edge, then the new value. No write-through bypass.
- After reset with no writes, rData = 0 for every rAddr.
- All address values are valid; there is no out-of-range case.
- No X propagation from a defined state: all outputs are defined once reset has been applied.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults and a NUM_REGS constant (2**ADDR_WIDTH).
- Sub-module register_cell:
  - One DATA_WIDTH-bit register with synchronous active-high clear and load enable.
  - Instantiated NUM_REGS times via generate.
- Top level contains:
  - a write-address decoder (one-hot enable = we AND wAddr==i);
  - the NUM_REGS-to-1 read multiplexer.

Test Plan:
- Reset: hold reset=1 for one edge, then reset=0, we=0 → rData=00000000 for rAddr=0..7.
- Sequential writes (one per edge, we=1):
  - wAddr0=11111111, wAddr1=FF00FF00, wAddr2=FF00FF00, wAddr3=00FF00FF.
  - Then we=0; sweep rAddr 0,1,2,3 → 11111111, FF00FF00, FF00FF00, 00FF00FF.
  - rAddr 4–7 → 00000000.
- Write-disable: we=0, wAddr=1, wData=DEADBEEF over several edges → rAddr=1 still reads FF00FF00.
- Same-address read/write: rAddr=5, wAddr=5, wData=A5A5A5A5, we=1 → rData=00000000 before the edge, A5A5A5A5 after it.
- Reset priority: reset=1 and we=1 with wAddr=3, wData=12345678 on the same edge → reg3 reads 00000000; all registers read 0 afterward.
- Combinational read: change rAddr between clock edges with registers loaded → rData updates without waiting for a clock edge.

Source files
------------

// File: rtl/register_file_8x32_pkg.sv
// Shared sizing constants for the 8x32 register file and its storage cells.
package register_file_8x32_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int NUM_REGS           = 2 ** DEFAULT_ADDR_WIDTH;

    function automatic int num_regs_for(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

// File: rtl/register_file_8x32_register_cell.sv
// One storage word with synchronous clear and load enable; clear wins over load.
module register_cell
    import register_file_8x32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/register_file_8x32.sv
// General-purpose register file: one synchronous write port, one combinational read port.
module register_file_8x32
    import register_file_8x32_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic [ADDR_WIDTH-1:0] rAddr,
    output logic [DATA_WIDTH-1:0] rData
);

    localparam int N_REGS = num_regs_for(ADDR_WIDTH);

    logic [N_REGS-1:0]     wr_en;
    logic [DATA_WIDTH-1:0] cell_q [N_REGS];

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (we && (wAddr == ADDR_WIDTH'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    // Every cell sees the shared clear, so reset overrides any pending write.
    for (genvar g = 0; g < N_REGS; g++) begin : g_cell
        register_cell #(
            .WIDTH (DATA_WIDTH)
        ) u_cell (
            .clk  (clk),
            .clr  (reset),
            .load (wr_en[g]),
            .d    (wData),
            .q    (cell_q[g])
        );
    end

    assign rData = cell_q[rAddr];

endmodule

// File: tb/tb_register_file_8x32.sv
// Directed self-checking bench for register_file_8x32.
module tb_register_file_8x32;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [2:0]  rAddr;
    logic [31:0] rData;

    int n_checks;
    int n_fail;

    register_file_8x32 dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wAddr (wAddr),
        .wData (wData),
        .rAddr (rAddr),
        .rData (rData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        we    = 1'b0;
        wAddr = '0;
        wData = '0;
        rAddr = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rAddr = 3'(i);
            #1;
            n_checks++;
            if (rData !== 32'h0000_0000) begin
                n_fail++;
                $display("FAIL reset_clear: rAddr=%0d got %h expected %h", i, rData, 32'h0);
            end
        end
    endtask

    task automatic test_sequential_writes();
        logic [31:0] vals [4];
        logic [31:0] exp_all [8];
        vals = '{32'h1111_1111, 32'hFF00_FF00, 32'hFF00_FF00, 32'h00FF_00FF};
        for (int i = 0; i < 4; i++) begin
            we    = 1'b1;
            wAddr = 3'(i);
            wData = vals[i];
            rAddr = 3'(i);
            @(posedge clk);
            #1;
            n_checks++;
            if (rData !== vals[i]) begin
                n_fail++;
                $display("FAIL write_latency: addr=%0d got %h expected %h", i, rData, vals[i]);
            end
        end
        we = 1'b0;
        exp_all = '{32'h1111_1111, 32'hFF00_FF00, 32'hFF00_FF00, 32'h00FF_00FF,
                    32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            rAddr = 3'(i);
            #1;
            n_checks++;
            if (rData !== exp_all[i]) begin
                n_fail++;
                $display("FAIL seq_sweep: rAddr=%0d got %h expected %h", i, rData, exp_all[i]);
            end
        end
    endtask

    task automatic test_write_disable();
        we    = 1'b0;
        wAddr = 3'd1;
        wData = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        rAddr = 3'd1;
        #1;
        n_checks++;
        if (rData !== 32'hFF00_FF00) begin
            n_fail++;
            $display("FAIL write_disable: rAddr=1 got %h expected %h", rData, 32'hFF00_FF00);
        end
        rAddr = 3'd4;
        #1;
        n_checks++;
        if (rData !== 32'h0) begin
            n_fail++;
            $display("FAIL write_disable_other: rAddr=4 got %h expected %h", rData, 32'h0);
        end
    endtask

    task automatic test_same_addr();
        rAddr = 3'd5;
        wAddr = 3'd5;
        wData = 32'hA5A5_A5A5;
        we    = 1'b1;
        #1;
        n_checks++;
        if (rData !== 32'h0) begin
            n_fail++;
            $display("FAIL same_addr_before: got %h expected %h", rData, 32'h0);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        n_checks++;
        if (rData !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL same_addr_after: got %h expected %h", rData, 32'hA5A5_A5A5);
        end
    endtask

    // Address changes land well inside one half-period so no edge intervenes.
    task automatic test_comb_read();
        logic [2:0]  addrs [4];
        logic [31:0] exps  [4];
        addrs = '{3'd3, 3'd5, 3'd0, 3'd6};
        exps  = '{32'h00FF_00FF, 32'hA5A5_A5A5, 32'h1111_1111, 32'h0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rAddr = addrs[i];
            #0.5;
            n_checks++;
            if (rData !== exps[i]) begin
                n_fail++;
                $display("FAIL comb_read: rAddr=%0d got %h expected %h", addrs[i], rData, exps[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        we    = 1'b1;
        wAddr = 3'd3;
        wData = 32'h1234_5678;
        rAddr = 3'd3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        n_checks++;
        if (rData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_priority: rAddr=3 got %h expected %h", rData, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            rAddr = 3'(i);
            #1;
            n_checks++;
            if (rData !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_priority_sweep: rAddr=%0d got %h expected %h", i, rData, 32'h0);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sequential_writes();
        test_write_disable();
        test_same_addr();
        test_comb_read();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
